// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Round-robin arbiter that shares one APB completer between NUM_REQ upstream
//   APB requesters. One requester is granted per transfer. Its request is replayed
//   downstream as SETUP/ACCESS, and the completer response is routed back to it.
//   A watchdog ends an ACCESS phase that lasts too long with PSLVERR, so a hung
//   completer cannot lock the bus.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_psel_i            per-requester PSEL
//   req_penable_i         per-requester PENABLE (gates the returned PREADY)
//   req_pwrite_i          per-requester PWRITE
//   req_paddr_i           per-requester PADDR, requester i at [i*ADDR_W +: ADDR_W]
//   req_pwdata_i          per-requester PWDATA, same packing
//   req_prdata_o          completer PRDATA broadcast to all requesters
//   req_pready_o          per-requester PREADY, only the granted bit can be set
//   req_pslverr_o         per-requester PSLVERR, valid with req_pready_o
//   m_psel_o/m_penable_o  downstream phase strobes
//   m_pwrite_o/m_paddr_o/m_pwdata_o  downstream request, registered at grant
//   m_prdata_i/m_pready_i/m_pslverr_i  downstream response
//   grant_o               one-hot owner of the current transfer, 0 when idle
//   timeout_o             single-cycle pulse when the watchdog ends a transfer

module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_psel_i,
  input  logic [NUM_REQ-1:0]          req_penable_i,
  input  logic [NUM_REQ-1:0]          req_pwrite_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_paddr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_pwdata_i,
  output logic [DATA_W-1:0]           req_prdata_o,
  output logic [NUM_REQ-1:0]          req_pready_o,
  output logic [NUM_REQ-1:0]          req_pslverr_o,
  output logic                        m_psel_o,
  output logic                        m_penable_o,
  output logic                        m_pwrite_o,
  output logic [ADDR_W-1:0]           m_paddr_o,
  output logic [DATA_W-1:0]           m_pwdata_o,
  input  logic [DATA_W-1:0]           m_prdata_i,
  input  logic                        m_pready_i,
  input  logic                        m_pslverr_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          WDOG_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_last;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [NUM_REQ-1:0]  w_win_onehot;
  int unsigned         w_scan;
  logic                w_timeout;
  logic                w_done;
  logic [NUM_REQ-1:0]  w_resp;

  // Round-robin pick: first requesting index after the last winner, wrapping around.
  always_comb begin
    w_found      = 1'b0;
    w_win_idx    = '0;
    w_scan       = 0;
    w_win_onehot = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan = (32'(r_last) + k) % NUM_REQ;
      if (!w_found && req_psel_i[IDX_W'(w_scan)]) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'(w_scan);
      end
    end
    w_win_onehot[w_win_idx] = w_found;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode. The response path is combinational so the requester sees
  // PREADY in the same cycle the completer gives it.
  always_comb begin
    m_psel_o      = 1'b0;
    m_penable_o   = 1'b0;
    w_timeout     = 1'b0;
    w_done        = 1'b0;
    w_resp        = '0;
    req_pready_o  = '0;
    req_pslverr_o = '0;
    timeout_o     = 1'b0;
    case (r_state)
      S_SETUP: begin
        m_psel_o = 1'b1;
      end
      S_ACCESS: begin
        m_psel_o    = 1'b1;
        m_penable_o = 1'b1;
        w_timeout   = WDOG_EN && !m_pready_i && (r_cnt == CNT_LAST);
        w_done      = m_pready_i || w_timeout;
        // A requester that has abandoned its transfer gets no response.
        w_resp        = w_done ? (r_grant & req_penable_i) : '0;
        req_pready_o  = w_resp;
        req_pslverr_o = (w_timeout || m_pslverr_i) ? w_resp : '0;
        timeout_o     = w_timeout;
      end
      default: ;
    endcase
  end

  // Grant, round-robin pointer, latched request and watchdog counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_grant  <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_win_onehot;
            r_last   <= w_win_idx;
            r_pwrite <= req_pwrite_i[w_win_idx];
            r_paddr  <= req_paddr_i[32'(w_win_idx) * ADDR_W +: ADDR_W];
            r_pwdata <= req_pwdata_i[32'(w_win_idx) * DATA_W +: DATA_W];
          end
        end
        S_SETUP: begin
          r_cnt <= '0;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_grant <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m_pwrite_o   = r_pwrite;
  assign m_paddr_o    = r_paddr;
  assign m_pwdata_o   = r_pwdata;
  assign grant_o      = r_grant;
  assign req_prdata_o = m_prdata_i;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Testbench for apb_rr_arbiter: directed scenarios plus a randomized run that is
// checked against a transaction-timeline reference model.

module tb_apb_rr_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     psel, penable, pwrite;
  logic [NR*AW-1:0]  paddr;
  logic [NR*DW-1:0]  pwdata;
  logic [DW-1:0]     prdata;
  logic [NR-1:0]     req_pready, req_pslverr;
  logic              m_psel, m_penable, m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic [DW-1:0]     m_prdata;
  logic              m_pready, m_pslverr;
  logic [NR-1:0]     grant;
  logic              timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_psel_i(psel), .req_penable_i(penable), .req_pwrite_i(pwrite),
    .req_paddr_i(paddr), .req_pwdata_i(pwdata),
    .req_prdata_o(prdata), .req_pready_o(req_pready), .req_pslverr_o(req_pslverr),
    .m_psel_o(m_psel), .m_penable_o(m_penable), .m_pwrite_o(m_pwrite),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic clear_inputs();
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_req(input int i);
    psel[i] = 1'b1;
    penable[i] = 1'b0;
    pwrite[i] = 1'($urandom);
    paddr[i*AW +: AW] = AW'($urandom);
    pwdata[i*DW +: DW] = $urandom;
  endtask

  // Reset held with busy inputs: every output except the PRDATA pass-through stays 0.
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    psel = 2'b11; penable = 2'b11; m_pready = 1'b1; m_pslverr = 1'b1;
    paddr = 24'hABC_DEF;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({m_psel, m_penable} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b exp=00", {m_psel, m_penable}); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if (req_pready !== 2'b00) begin errors++; $display("FAIL rst_pready got=%b exp=00", req_pready); end
    checks++; if (req_pslverr !== 2'b00) begin errors++; $display("FAIL rst_pslverr got=%b exp=00", req_pslverr); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    checks++; if ({m_pwrite, m_paddr, m_pwdata} !== '0) begin errors++; $display("FAIL rst_mreq got=%h exp=0", {m_pwrite, m_paddr, m_pwdata}); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    psel = 2'b01; paddr[0 +: AW] = 12'h123; #1;
    checks++; if ({m_psel, m_penable, grant} !== 4'b0) begin errors++; $display("FAIL sr_idle got=%b exp=0000", {m_psel, m_penable, grant}); end
    @(negedge clk); penable = 2'b01; #1;
    checks++; if ({m_psel, m_penable} !== 2'b10) begin errors++; $display("FAIL sr_setup got=%b exp=10", {m_psel, m_penable}); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sr_grant got=%b exp=01", grant); end
    checks++; if (m_paddr !== 12'h123) begin errors++; $display("FAIL sr_paddr got=%h exp=123", m_paddr); end
    checks++; if (req_pready !== 2'b00) begin errors++; $display("FAIL sr_early_pready got=%b exp=00", req_pready); end
    @(negedge clk); m_pready = 1'b1; m_prdata = 32'hCAFE_0123; #1;
    checks++; if ({m_psel, m_penable} !== 2'b11) begin errors++; $display("FAIL sr_access got=%b exp=11", {m_psel, m_penable}); end
    checks++; if (req_pready !== 2'b01) begin errors++; $display("FAIL sr_pready got=%b exp=01", req_pready); end
    checks++; if (prdata !== 32'hCAFE_0123) begin errors++; $display("FAIL sr_prdata got=%h exp=cafe0123", prdata); end
    @(negedge clk); psel = '0; penable = '0; m_pready = 1'b0; #1;
    checks++; if ({m_psel, grant, req_pready} !== 5'b0) begin errors++; $display("FAIL sr_back_idle got=%b exp=00000", {m_psel, grant, req_pready}); end
  endtask

  task automatic test_contention();
    do_reset();
    psel = 2'b11; paddr[0 +: AW] = 12'h010; paddr[AW +: AW] = 12'h020; #1;
    @(negedge clk); penable = 2'b11; #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ct_first_grant got=%b exp=01", grant); end
    checks++; if (m_paddr !== 12'h010) begin errors++; $display("FAIL ct_first_paddr got=%h exp=010", m_paddr); end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b01) begin errors++; $display("FAIL ct_first_pready got=%b exp=01", req_pready); end
    // req0 immediately starts another transfer while req1 is still waiting.
    @(negedge clk); m_pready = 1'b0; penable[0] = 1'b0; paddr[0 +: AW] = 12'h030; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ct_idle_grant got=%b exp=00", grant); end
    @(negedge clk); penable[0] = 1'b1; #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ct_rr_grant got=%b exp=10", grant); end
    checks++; if (m_paddr !== 12'h020) begin errors++; $display("FAIL ct_rr_paddr got=%h exp=020", m_paddr); end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b10) begin errors++; $display("FAIL ct_rr_pready got=%b exp=10", req_pready); end
    @(negedge clk); m_pready = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0; #1;
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL ct_gap_psel got=%b exp=0", m_psel); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || m_paddr !== 12'h030) begin errors++; $display("FAIL ct_third got=%b/%h exp=01/030", grant, m_paddr); end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b01) begin errors++; $display("FAIL ct_third_pready got=%b exp=01", req_pready); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    psel = 2'b10; pwrite = 2'b10; paddr[AW +: AW] = 12'h010; pwdata[DW +: DW] = 32'hA5A5_A5A5; #1;
    @(negedge clk); penable = 2'b10; #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ws_grant got=%b exp=10", grant); end
    checks++; if ({m_pwrite, m_paddr, m_pwdata} !== {1'b1, 12'h010, 32'hA5A5_A5A5}) begin errors++; $display("FAIL ws_setup_req got=%h exp=%h", {m_pwrite, m_paddr, m_pwdata}, {1'b1, 12'h010, 32'hA5A5_A5A5}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if ({m_penable, m_paddr, m_pwdata} !== {1'b1, 12'h010, 32'hA5A5_A5A5}) begin errors++; $display("FAIL ws_hold%0d got=%h exp=%h", k, {m_penable, m_paddr, m_pwdata}, {1'b1, 12'h010, 32'hA5A5_A5A5}); end
      checks++; if (req_pready !== 2'b00) begin errors++; $display("FAIL ws_wait%0d got=%b exp=00", k, req_pready); end
    end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b10 || req_pslverr !== 2'b00) begin errors++; $display("FAIL ws_done got=%b/%b exp=10/00", req_pready, req_pslverr); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    psel = 2'b11; paddr[0 +: AW] = 12'h111; paddr[AW +: AW] = 12'h222; #1;
    @(negedge clk); penable = 2'b11; #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_grant got=%b exp=01", grant); end
    for (int k = 0; k < int'(TO) - 1; k++) begin
      @(negedge clk); #1;
      checks++; if ({timeout, req_pready} !== 3'b0) begin errors++; $display("FAIL to_early%0d got=%b exp=000", k, {timeout, req_pready}); end
    end
    @(negedge clk); #1;
    checks++; if ({req_pready, req_pslverr, timeout} !== 5'b01_01_1) begin errors++; $display("FAIL to_fire got=%b exp=01011", {req_pready, req_pslverr, timeout}); end
    @(negedge clk); psel[0] = 1'b0; penable[0] = 1'b0; #1;
    checks++; if ({timeout, m_psel} !== 2'b00) begin errors++; $display("FAIL to_pulse_end got=%b exp=00", {timeout, m_psel}); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || m_paddr !== 12'h222) begin errors++; $display("FAIL to_next got=%b/%h exp=10/222", grant, m_paddr); end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b10 || timeout !== 1'b0) begin errors++; $display("FAIL to_next_done got=%b/%b exp=10/0", req_pready, timeout); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_pslverr();
    do_reset();
    psel = 2'b11; #1;
    @(negedge clk); penable = 2'b11; #1;
    @(negedge clk); m_pready = 1'b1; m_pslverr = 1'b1; #1;
    checks++; if ({req_pready, req_pslverr} !== 4'b01_01) begin errors++; $display("FAIL se_err got=%b exp=0101", {req_pready, req_pslverr}); end
    @(negedge clk); m_pready = 1'b0; m_pslverr = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if ({req_pready, req_pslverr} !== 4'b10_00) begin errors++; $display("FAIL se_ok got=%b exp=1000", {req_pready, req_pslverr}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_abandon();
    do_reset();
    psel = 2'b01; #1;
    @(negedge clk); penable = 2'b01; #1;
    @(negedge clk); #1;
    @(negedge clk); psel = '0; penable = '0; m_pready = 1'b1; #1;
    checks++; if ({m_psel, m_penable, req_pready} !== 4'b11_00) begin errors++; $display("FAIL ab_discard got=%b exp=1100", {m_psel, m_penable, req_pready}); end
    @(negedge clk); m_pready = 1'b0; #1;
    checks++; if ({m_psel, grant} !== 3'b0) begin errors++; $display("FAIL ab_idle got=%b exp=000", {m_psel, grant}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    psel = 2'b10; pwrite = 2'b10; paddr[AW +: AW] = 12'h0FF; pwdata[DW +: DW] = 32'h1234_5678; #1;
    @(negedge clk); penable = 2'b10; #1;
    @(negedge clk); #1;
    checks++; if (m_penable !== 1'b1) begin errors++; $display("FAIL rm_access got=%b exp=1", m_penable); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; m_pready = 1'b1; psel = 2'b11; penable = 2'b10; #1;
    checks++; if ({m_psel, m_penable, grant, req_pready, req_pslverr, timeout} !== '0) begin errors++; $display("FAIL rm_outputs got=%b exp=0", {m_psel, m_penable, grant, req_pready, req_pslverr, timeout}); end
    checks++; if ({m_pwrite, m_paddr, m_pwdata} !== '0) begin errors++; $display("FAIL rm_mreq got=%h exp=0", {m_pwrite, m_paddr, m_pwdata}); end
    @(negedge clk); m_pready = 1'b0; penable = 2'b11; #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_regrant got=%b exp=01", grant); end
    @(negedge clk); m_pready = 1'b1; #1;
    checks++; if (req_pready !== 2'b01) begin errors++; $display("FAIL rm_pready got=%b exp=01", req_pready); end
    @(negedge clk); clear_inputs();
  endtask

  // Random traffic. The model schedules each transfer on a timeline: decided in the
  // idle cycle it sees requests, SETUP the next cycle, then one ACCESS cycle per wait
  // state plus one, capped at TO ACCESS cycles when the watchdog fires.
  task automatic test_random();
    int unsigned   last;
    bit            have;
    bit            e_to;
    bit            found;
    bit            in_txn;
    int            w;
    int            t_setup;
    int            t_end;
    int unsigned   ws_cur;
    int unsigned   acc_cnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_write;
    logic [NR-1:0] fin, oh, e_pready, e_pslverr;
    last = NR - 1; have = 1'b0; e_to = 1'b0; w = 0; t_setup = 0; t_end = 0;
    ws_cur = 0; acc_cnt = 0; e_addr = '0; e_wdata = '0; e_write = 1'b0; fin = '0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < int'(NR); i++) begin
        if (fin[i]) begin
          psel[i] = 1'b0; penable[i] = 1'b0; fin[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) start_req(i);
        end else if (psel[i]) begin
          penable[i] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          start_req(i);
        end
      end
      m_pready  = (m_psel && m_penable && acc_cnt == ws_cur);
      m_pslverr = 1'($urandom);
      m_prdata  = $urandom;
      #1;
      in_txn = have && cyc >= t_setup && cyc <= t_end;
      oh = '0; oh[w] = 1'b1;
      e_pready  = (have && cyc == t_end) ? (oh & penable) : '0;
      e_pslverr = (e_to || m_pslverr) ? e_pready : '0;
      checks++; if (m_psel !== in_txn) begin errors++; $display("FAIL rnd_psel cyc=%0d got=%b exp=%b", cyc, m_psel, in_txn); end
      checks++; if (m_penable !== (in_txn && cyc > t_setup)) begin errors++; $display("FAIL rnd_penable cyc=%0d got=%b exp=%b", cyc, m_penable, in_txn && cyc > t_setup); end
      checks++; if (grant !== (in_txn ? oh : 2'b00)) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant, in_txn ? oh : 2'b00); end
      if (in_txn) begin
        checks++; if ({m_pwrite, m_paddr, m_pwdata} !== {e_write, e_addr, e_wdata}) begin errors++; $display("FAIL rnd_mreq cyc=%0d got=%h exp=%h", cyc, {m_pwrite, m_paddr, m_pwdata}, {e_write, e_addr, e_wdata}); end
      end
      checks++; if (req_pready !== e_pready) begin errors++; $display("FAIL rnd_pready cyc=%0d got=%b exp=%b", cyc, req_pready, e_pready); end
      checks++; if (req_pslverr !== e_pslverr) begin errors++; $display("FAIL rnd_pslverr cyc=%0d got=%b exp=%b", cyc, req_pslverr, e_pslverr); end
      checks++; if (timeout !== (have && cyc == t_end && e_to)) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, timeout, have && cyc == t_end && e_to); end
      checks++; if (prdata !== m_prdata) begin errors++; $display("FAIL rnd_prdata cyc=%0d got=%h exp=%h", cyc, prdata, m_prdata); end
      for (int i = 0; i < int'(NR); i++) if (req_pready[i]) fin[i] = 1'b1;
      acc_cnt = (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;
      if ((!have || cyc > t_end) && psel != '0) begin
        found = 1'b0;
        for (int k = 1; k <= int'(NR); k++) begin
          int idx;
          idx = (int'(last) + k) % int'(NR);
          if (!found && psel[idx]) begin found = 1'b1; w = idx; end
        end
        last    = w;
        have    = 1'b1;
        t_setup = cyc + 1;
        ws_cur  = $urandom_range(0, 10);
        e_to    = (ws_cur >= TO);
        t_end   = e_to ? t_setup + int'(TO) : t_setup + 1 + int'(ws_cur);
        e_addr  = paddr[w*AW +: AW];
        e_wdata = pwdata[w*DW +: DW];
        e_write = pwrite[w];
      end
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_timeout();
    test_pslverr();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
